// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative, write-back, write-allocate data cache
// with true-LRU replacement and a line-wide request/acknowledge memory port.
//
// state     | meaning
// ----------|----------------------------------------------------------
// IDLE      | serving hits; a miss latches the request and picks a victim
// WRITEBACK | dirty victim line being written to memory
// FILL      | missing line being read from memory into the victim way
module assoc_cache #(
    parameter int WAYS  = 2,
    parameter int SETS  = 4,
    parameter int WORDS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read,
    input  logic                we,
    input  logic [31:0]         a,
    input  logic [31:0]         wd,
    output logic [31:0]         rd,
    output logic                ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [WORDS*32-1:0] mem_wd,
    input  logic [WORDS*32-1:0] mem_rd,
    input  logic                mem_ack
);
    localparam int OB = $clog2(WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TW = 32 - OB - IB - 2;
    localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [AW-1:0] AGE_LRU = AW'(WAYS - 1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
    state_t state, state_nx;

    logic [WORDS*32-1:0] data_q  [WAYS][SETS];
    logic [TW-1:0]       tag_q   [WAYS][SETS];
    logic                valid_q [WAYS][SETS];
    logic                dirty_q [WAYS][SETS];
    logic [AW-1:0]       age_q   [WAYS][SETS];

    logic [TW-1:0] lat_tag;
    logic [IB-1:0] lat_index;
    logic [AW-1:0] lat_victim;

    logic [OB-1:0]       req_word;
    logic [IB-1:0]       req_index;
    logic [TW-1:0]       req_tag;
    logic                req;
    logic                store;
    logic                hit;
    logic [AW-1:0]       hit_way;
    logic [AW-1:0]       victim;
    logic                found_invalid;
    logic [WORDS*32-1:0] hit_line;
    logic                addr_unused;

    assign req_word    = a[OB+1:2];
    assign req_index   = a[OB+IB+1:OB+2];
    assign req_tag     = a[31:OB+IB+2];
    assign req         = read | we;
    assign store       = we & ~read;
    assign hit_line    = data_q[hit_way][req_index];
    assign addr_unused = ^a[1:0];

    // tag compare across all ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_index] && tag_q[w][req_index] == req_tag) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
        end
    end

    // victim: lowest-numbered invalid way, otherwise the LRU way
    always_comb begin
        victim        = '0;
        found_invalid = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_invalid && !valid_q[w][req_index]) begin
                victim        = AW'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[w][req_index] == AGE_LRU) victim = AW'(w);
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req && !hit)
                    state_nx = (valid_q[victim][req_index] && dirty_q[victim][req_index])
                               ? WRITEBACK : FILL;
            end
            WRITEBACK: if (mem_ack) state_nx = FILL;
            FILL:      if (mem_ack) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // outputs; everything is forced quiet while reset is held low
    always_comb begin
        ready    = 1'b0;
        rd       = '0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (reset) begin
            case (state)
                IDLE: begin
                    ready = !req || hit;
                    if (read && hit) rd = hit_line[req_word*32 +: 32];
                end
                WRITEBACK: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = {tag_q[lat_victim][lat_index], lat_index, {(OB+2){1'b0}}};
                    mem_wd   = data_q[lat_victim][lat_index];
                end
                FILL: begin
                    mem_req  = 1'b1;
                    mem_addr = {lat_tag, lat_index, {(OB+2){1'b0}}};
                end
                default: ;
            endcase
        end
    end

    // valid/dirty/LRU bookkeeping and the miss latch
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    age_q[w][s]   <= AW'(w);
                end
            end
            lat_tag    <= '0;
            lat_index  <= '0;
            lat_victim <= '0;
        end else begin
            if (state == IDLE && req && hit) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AW'(w) == hit_way)
                        age_q[w][req_index] <= '0;
                    else if (age_q[w][req_index] < age_q[hit_way][req_index])
                        age_q[w][req_index] <= age_q[w][req_index] + 1'b1;
                end
                if (store) dirty_q[hit_way][req_index] <= 1'b1;
            end
            if (state == IDLE && req && !hit) begin
                lat_tag    <= req_tag;
                lat_index  <= req_index;
                lat_victim <= victim;
            end
            if (state == FILL && mem_ack) begin
                valid_q[lat_victim][lat_index] <= 1'b1;
                dirty_q[lat_victim][lat_index] <= 1'b0;
            end
        end
    end

    // data and tag arrays carry no reset; only written outside reset
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == IDLE && store && hit)
                data_q[hit_way][req_index][req_word*32 +: 32] <= wd;
            if (state == FILL && mem_ack) begin
                data_q[lat_victim][lat_index] <= mem_rd;
                tag_q[lat_victim][lat_index]  <= lat_tag;
            end
        end
    end
endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache: a reference memory model predicts load data,
// a queue holds expected loads until the cache reports ready.
module tb_assoc_cache;
    localparam int WORDS = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                read = 1'b0;
    logic                we = 1'b0;
    logic [31:0]         a = '0;
    logic [31:0]         wd = '0;
    logic [31:0]         rd;
    logic                ready;
    logic                mem_req;
    logic                mem_we;
    logic [31:0]         mem_addr;
    logic [WORDS*32-1:0] mem_wd;
    logic [WORDS*32-1:0] mem_rd = '0;
    logic                mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] back_mem [logic [31:0]];

    always #5 clk = ~clk;

    assoc_cache #(.WAYS(2), .SETS(4), .WORDS(WORDS)) dut (
        .clk(clk), .reset(reset), .read(read), .we(we), .a(a), .wd(wd),
        .rd(rd), .ready(ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_ack(mem_ack)
    );

    function automatic logic [31:0] back_word(input logic [31:0] addr);
        if (back_mem.exists(addr)) return back_mem[addr];
        return 32'h1000 + {2'b00, addr[31:2]};
    endfunction

    function automatic logic [31:0] cpu_word(input logic [31:0] addr);
        if (ref_mem.exists(addr)) return ref_mem[addr];
        return back_word(addr);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    // previous request is consumed at this posedge; the new one starts now
    task automatic issue(input logic r, input logic w, input logic [31:0] addr,
                         input logic [31:0] data);
        @(posedge clk); #1;
        read = r; we = w; a = addr; wd = data;
        if (r) exp_q.push_back(cpu_word({addr[31:2], 2'b00}));
        else if (w) ref_mem[{addr[31:2], 2'b00}] = data;
    endtask

    task automatic finish_req(input string tag);
        logic [31:0] exp;
        @(negedge clk);
        check1({tag, "_ready"}, ready, 1'b1);
        check1({tag, "_noreq"}, mem_req, 1'b0);
        if (read) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $error("FAIL %s_sb observed=empty expected=entry", tag);
            end else begin
                exp = exp_q.pop_front();
                check({tag, "_rd"}, rd, exp);
            end
        end else begin
            check({tag, "_rd0"}, rd, 32'h0);
        end
    endtask

    task automatic miss_check(input string tag);
        @(negedge clk);
        check1({tag, "_ready0"}, ready, 1'b0);
        check1({tag, "_req0"}, mem_req, 1'b0);
        check({tag, "_rd0"}, rd, 32'h0);
    endtask

    // one memory transaction, required to be presented in the very next cycle
    task automatic serve(input string tag, input logic mw, input logic [31:0] addr,
                         input int lat, input logic chk1, input logic [31:0] exp1);
        logic [WORDS*32-1:0] line;
        @(negedge clk);
        check1({tag, "_req"}, mem_req, 1'b1);
        check1({tag, "_we"}, mem_we, mw);
        check({tag, "_addr"}, mem_addr, addr);
        if (mw && chk1) check({tag, "_wd1"}, mem_wd[63:32], exp1);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check1({tag, "_hold_req"}, mem_req, 1'b1);
            check1({tag, "_hold_we"}, mem_we, mw);
            check({tag, "_hold_addr"}, mem_addr, addr);
            check1({tag, "_hold_ready"}, ready, 1'b0);
        end
        line = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (mw) back_mem[addr + 32'(4*k)] = mem_wd[k*32 +: 32];
            else    line[k*32 +: 32] = back_word(addr + 32'(4*k));
        end
        mem_rd = line;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held for two cycles
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check1("rst_ready", ready, 1'b0);
            check1("rst_req", mem_req, 1'b0);
            check("rst_rd", rd, 32'h0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check1("idle_ready", ready, 1'b1);
        check1("idle_req", mem_req, 1'b0);
        check("idle_rd", rd, 32'h0);

        // first fill, two cycles of extra latency
        issue(1'b1, 1'b0, 32'h000, 32'h0);
        miss_check("a_miss");
        serve("a_fill", 1'b0, 32'h000, 2, 1'b0, 32'h0);
        finish_req("a_done");

        // store hit then load hit
        issue(1'b0, 1'b1, 32'h004, 32'hDEADBEEF);
        finish_req("b_store");
        issue(1'b1, 1'b0, 32'h004, 32'h0);
        finish_req("b_load");

        // 0x080 into the invalid way, 0x000 hit, 0x100 replaces clean 0x080
        issue(1'b1, 1'b0, 32'h080, 32'h0);
        miss_check("c_miss80");
        serve("c_fill80", 1'b0, 32'h080, 0, 1'b0, 32'h0);
        finish_req("c_done80");
        issue(1'b1, 1'b0, 32'h000, 32'h0);
        finish_req("c_hit0");
        issue(1'b1, 1'b0, 32'h100, 32'h0);
        miss_check("c_miss100");
        serve("c_fill100", 1'b0, 32'h100, 1, 1'b0, 32'h0);
        finish_req("c_done100");
        issue(1'b1, 1'b0, 32'h000, 32'h0);
        finish_req("c_still0");
        issue(1'b1, 1'b0, 32'h100, 32'h0);
        finish_req("c_hit100");

        // dirty 0x000 is now LRU: writeback then fill
        issue(1'b1, 1'b0, 32'h080, 32'h0);
        miss_check("c_miss80b");
        serve("c_wb0", 1'b1, 32'h000, 1, 1'b1, 32'hDEADBEEF);
        serve("c_refill80", 1'b0, 32'h080, 0, 1'b0, 32'h0);
        finish_req("c_done80b");

        // slow fill brings the written-back data home
        issue(1'b1, 1'b0, 32'h000, 32'h0);
        miss_check("d_miss0");
        serve("d_fill0", 1'b0, 32'h000, 5, 1'b0, 32'h0);
        finish_req("d_done0");
        issue(1'b1, 1'b0, 32'h004, 32'h0);
        finish_req("d_hit4");

        // reset in the middle of a fill, then a stray late ack
        issue(1'b1, 1'b0, 32'h200, 32'h0);
        miss_check("e_miss");
        @(negedge clk);
        check1("e_req", mem_req, 1'b1);
        check("e_addr", mem_addr, 32'h200);
        repeat (2) begin
            @(negedge clk);
            check1("e_hold_req", mem_req, 1'b1);
            check1("e_hold_ready", ready, 1'b0);
        end
        reset = 1'b0;
        @(negedge clk);
        check1("e_rst_req", mem_req, 1'b0);
        check1("e_rst_ready", ready, 1'b0);
        check("e_rst_rd", rd, 32'h0);
        read = 1'b0;
        void'(exp_q.pop_front());
        ref_mem.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        check1("e_late_ready", ready, 1'b1);
        check1("e_late_req", mem_req, 1'b0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        issue(1'b1, 1'b0, 32'h200, 32'h0);
        miss_check("e_remiss");
        serve("e_fill", 1'b0, 32'h200, 0, 1'b0, 32'h0);
        finish_req("e_done");

        // read and write together act as a read only
        issue(1'b1, 1'b1, 32'h000, 32'h55);
        miss_check("f_miss");
        serve("f_fill", 1'b0, 32'h000, 0, 1'b0, 32'h0);
        finish_req("f_rw_miss");
        issue(1'b1, 1'b0, 32'h000, 32'h0);
        finish_req("f_load0");
        issue(1'b1, 1'b1, 32'h004, 32'h55);
        finish_req("f_rw_hit");
        issue(1'b1, 1'b0, 32'h004, 32'h0);
        finish_req("f_load4");

        @(posedge clk); #1;
        read = 1'b0; we = 1'b0;
        @(negedge clk);
        check1("end_ready", ready, 1'b1);
        check("end_rd", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
